// File: rtl/axi4_scratchpad_slave_pkg.sv
// Shared AXI encodings, FSM state codes and burst legality check for the scratchpad slave.
package axi4_scratchpad_slave_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_READ = 2'd1;
   localparam logic [1:0] R_DATA = 2'd2;

   // Reserved burst type, beats wider than the 64-bit bus, or an illegal WRAP length.
   function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size,
                                      input logic [7:0] len);
      logic wrap_len_ok;
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      return (burst == 2'b11) || (size > 3'd3) || ((burst == BURST_WRAP) && !wrap_len_ok);
   endfunction

endpackage

// File: rtl/axi4_scratchpad_slave_if.sv
// AXI4 slave-side bus bundle; lock/cache/prot/qos are carried but unused by the slave.
interface axi4_scratchpad_slave_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32
);
   logic              awvalid, awready;
   logic [ID_W-1:0]   awid;
   logic [ADDR_W-1:0] awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awlock;
   logic [3:0]        awcache, awqos;
   logic [2:0]        awprot;
   logic              wvalid, wready, wlast;
   logic [63:0]       wdata;
   logic [7:0]        wstrb;
   logic              bvalid, bready;
   logic [ID_W-1:0]   bid;
   logic [1:0]        bresp;
   logic              arvalid, arready;
   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arlock;
   logic [3:0]        arcache, arqos;
   logic [2:0]        arprot;
   logic              rvalid, rready, rlast;
   logic [ID_W-1:0]   rid;
   logic [63:0]       rdata;
   logic [1:0]        rresp;

   modport slave (
      input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bid, bresp,
      input  bready,
      input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
      output arready,
      output rvalid, rid, rdata, rresp, rlast,
      input  rready
   );

   modport master (
      output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bid, bresp,
      output bready,
      output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
      input  arready,
      input  rvalid, rid, rdata, rresp, rlast,
      output rready
   );
endinterface

// File: rtl/axi4_scratchpad_slave_ram.sv
// 1R1W scratchpad storage with byte write enables and a registered, read-first read port.
module scratchpad_ram #(
   parameter int  DEPTH  = 512,
   parameter int  DATA_W = 64,
   localparam int IDX_W  = $clog2(DEPTH),
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [BE_W-1:0]   wbe_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Non-blocking update makes a same-edge read see the pre-write word.
   always_ff @(posedge clk_i) begin
      if (re_i) rdata_q <= mem_q[raddr_i];
      if (we_i) begin
         for (int b = 0; b < BE_W; b++) begin
            if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/axi4_scratchpad_slave.sv
// AXI4 scratchpad slave: independent single-outstanding read and write FSMs over a 1R1W RAM.
module axi4_scratchpad_slave
   import axi4_scratchpad_slave_pkg::*;
#(
   parameter int                ID_W      = 4,
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 64,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h6000_0000,
   parameter int                DEPTH     = 512
) (
   input logic                   clock,
   input logic                   reset,
   axi4_scratchpad_slave_if.slave S_AXI
);
   localparam int IDX_W = $clog2(DEPTH);

   function automatic logic in_win(input logic [ADDR_W-1:0] a);
      logic [ADDR_W:0] lim;
      lim = {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH * 8);
      return (a >= BASE_ADDR) && ({1'b0, a} < lim);
   endfunction

   // Bits above the window are dropped, so INCR bursts past the top wrap to word 0.
   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] offs;
      offs = a - BASE_ADDR;
      return offs[IDX_W+2:3];
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      logic [ADDR_W-1:0] inc, mask;
      inc  = a + (ADDR_W'(1) << size);
      mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
      case (burst)
         BURST_FIXED: return a;
         BURST_WRAP:  return (a & ~mask) | (inc & mask);
         default:     return inc;
      endcase
   endfunction

   logic [1:0]        w_state_q, w_state_d, r_state_q, r_state_d;
   logic [ADDR_W-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
   logic [7:0]        aw_len_q, aw_len_d, ar_len_q, ar_len_d, beat_q, beat_d;
   logic [2:0]        aw_size_q, aw_size_d, ar_size_q, ar_size_d;
   logic [1:0]        aw_burst_q, aw_burst_d, ar_burst_q, ar_burst_d;
   logic [ID_W-1:0]   aw_id_q, aw_id_d, ar_id_q, ar_id_d;
   logic [1:0]        b_resp_q, b_resp_d, r_resp_q, r_resp_d;
   logic              ram_we, ram_re;
   logic [DATA_W-1:0] ram_rdata;

   always_comb begin
      w_state_d  = w_state_q;
      aw_addr_d  = aw_addr_q;
      aw_len_d   = aw_len_q;
      aw_size_d  = aw_size_q;
      aw_burst_d = aw_burst_q;
      aw_id_d    = aw_id_q;
      b_resp_d   = b_resp_q;
      ram_we     = 1'b0;
      case (w_state_q)
         W_IDLE: if (S_AXI.awvalid) begin
            aw_addr_d  = S_AXI.awaddr;
            aw_len_d   = S_AXI.awlen;
            aw_size_d  = S_AXI.awsize;
            aw_burst_d = S_AXI.awburst;
            aw_id_d    = S_AXI.awid;
            b_resp_d   = !in_win(S_AXI.awaddr) ? RESP_DECERR :
                         burst_err(S_AXI.awburst, S_AXI.awsize, S_AXI.awlen) ? RESP_SLVERR :
                         RESP_OKAY;
            w_state_d  = W_DATA;
         end
         W_DATA: if (S_AXI.wvalid) begin
            ram_we    = (b_resp_q == RESP_OKAY) && !reset;
            aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
            if (S_AXI.wlast) w_state_d = W_RESP;
         end
         W_RESP: if (S_AXI.bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d  = r_state_q;
      ar_addr_d  = ar_addr_q;
      ar_len_d   = ar_len_q;
      ar_size_d  = ar_size_q;
      ar_burst_d = ar_burst_q;
      ar_id_d    = ar_id_q;
      r_resp_d   = r_resp_q;
      beat_d     = beat_q;
      ram_re     = 1'b0;
      case (r_state_q)
         R_IDLE: if (S_AXI.arvalid) begin
            ar_addr_d  = S_AXI.araddr;
            ar_len_d   = S_AXI.arlen;
            ar_size_d  = S_AXI.arsize;
            ar_burst_d = S_AXI.arburst;
            ar_id_d    = S_AXI.arid;
            beat_d     = 8'd0;
            r_resp_d   = !in_win(S_AXI.araddr) ? RESP_DECERR :
                         burst_err(S_AXI.arburst, S_AXI.arsize, S_AXI.arlen) ? RESP_SLVERR :
                         RESP_OKAY;
            r_state_d  = R_READ;
         end
         R_READ: begin
            ram_re    = 1'b1;
            r_state_d = R_DATA;
         end
         R_DATA: if (S_AXI.rready) begin
            if (beat_q == ar_len_q) begin
               r_state_d = R_IDLE;
            end else begin
               beat_d    = beat_q + 8'd1;
               ar_addr_d = next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
               r_state_d = R_READ;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         w_state_q  <= W_IDLE;
         aw_addr_q  <= '0;
         aw_len_q   <= '0;
         aw_size_q  <= '0;
         aw_burst_q <= '0;
         aw_id_q    <= '0;
         b_resp_q   <= RESP_OKAY;
         r_state_q  <= R_IDLE;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         ar_burst_q <= '0;
         ar_id_q    <= '0;
         r_resp_q   <= RESP_OKAY;
         beat_q     <= '0;
      end else begin
         w_state_q  <= w_state_d;
         aw_addr_q  <= aw_addr_d;
         aw_len_q   <= aw_len_d;
         aw_size_q  <= aw_size_d;
         aw_burst_q <= aw_burst_d;
         aw_id_q    <= aw_id_d;
         b_resp_q   <= b_resp_d;
         r_state_q  <= r_state_d;
         ar_addr_q  <= ar_addr_d;
         ar_len_q   <= ar_len_d;
         ar_size_q  <= ar_size_d;
         ar_burst_q <= ar_burst_d;
         ar_id_q    <= ar_id_d;
         r_resp_q   <= r_resp_d;
         beat_q     <= beat_d;
      end
   end

   scratchpad_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ram (
      .clk_i   (clock),
      .we_i    (ram_we),
      .waddr_i (word_idx(aw_addr_q)),
      .wdata_i (S_AXI.wdata),
      .wbe_i   (S_AXI.wstrb),
      .re_i    (ram_re),
      .raddr_i (word_idx(ar_addr_q)),
      .rdata_o (ram_rdata)
   );

   assign S_AXI.awready = (w_state_q == W_IDLE);
   assign S_AXI.wready  = (w_state_q == W_DATA);
   assign S_AXI.bvalid  = (w_state_q == W_RESP);
   assign S_AXI.bid     = aw_id_q;
   assign S_AXI.bresp   = b_resp_q;
   assign S_AXI.arready = (r_state_q == R_IDLE);
   assign S_AXI.rvalid  = (r_state_q == R_DATA);
   assign S_AXI.rid     = ar_id_q;
   assign S_AXI.rresp   = r_resp_q;
   assign S_AXI.rlast   = (r_state_q == R_DATA) && (beat_q == ar_len_q);
   assign S_AXI.rdata   = ((r_state_q == R_DATA) && (r_resp_q == RESP_OKAY)) ? ram_rdata : '0;
endmodule

// File: doc/axi4_scratchpad_slave.md
AXI4_SCRATCHPAD_SLAVE -- requirements
Module: axi4_scratchpad_slave

Interface
REQ-001 Parameters SHALL be: ID_W, default 4, AXI ID width; ADDR_W, default 32, address width; DATA_W, fixed 64, data width; BASE_ADDR, default 32'h6000_0000, window base; DEPTH, default 512, 64-bit words (4 KiB window).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 S_AXI_aw{valid,id,addr,len,size,burst}  in  1/ID_W/ADDR_W/8/3/2  write address channel.
REQ-006 S_AXI_awready  out  1  write address accept.
REQ-007 S_AXI_w{valid,data,strb,last}  in  1/64/8/1  write data channel; S_AXI_wready  out  1.
REQ-008 S_AXI_b{valid,id,resp}  out  1/ID_W/2  write response; S_AXI_bready  in  1.
REQ-009 S_AXI_ar{valid,id,addr,len,size,burst}  in  1/ID_W/ADDR_W/8/3/2  read address channel; S_AXI_arready  out  1.
REQ-010 S_AXI_r{valid,id,data,resp,last}  out  1/ID_W/64/2/1  read data channel; S_AXI_rready  in  1.
REQ-011 lock, cache, prot, qos inputs SHALL be accepted and ignored.

Function
REQ-012 Read and write paths SHALL be independent FSMs; one outstanding transaction per direction.
REQ-013 Write FSM states: W_IDLE (awready=1) -> W_DATA on AW handshake -> W_RESP when the handshake carries wlast=1 -> W_IDLE on B handshake.
REQ-014 In W_DATA wready SHALL be 1; each W handshake writes bytes where wstrb=1, then advances the beat address.
REQ-015 Read FSM states: R_IDLE (arready=1) -> R_READ (memory read issued) -> R_DATA (rvalid=1 held until rready) -> R_READ for the next beat, or R_IDLE after the beat with rlast=1.
REQ-016 Read throughput SHALL be one beat per two cycles; first rvalid SHALL assert 2 cycles after the AR handshake.
REQ-017 rlast SHALL be 1 exactly on beat len+1; rid/bid SHALL equal the captured arid/awid.
REQ-018 Beat address update: FIXED (00) unchanged; INCR (01) +(1<<size); WRAP (10) +(1<<size) wrapping within a (len+1)<<size aligned region.
REQ-019 Word index SHALL be (addr-BASE_ADDR)[11:3]; offsets within a word are carried by strobes only (no lane steering).
REQ-020 Address outside [BASE_ADDR, BASE_ADDR+DEPTH*8) at AW/AR acceptance: resp DECERR (2'b11) for the whole burst, writes dropped, rdata 0.
REQ-021 burst=2'b11, size>3, or WRAP with len not in {1,3,7,15}: resp SLVERR (2'b10), writes dropped, rdata 0; beat count still honoured.
REQ-022 INCR bursts crossing the window top: beats outside the window SHALL wrap modulo DEPTH (no error); the decode of REQ-020 uses the start address only.
REQ-023 Same-cycle read and write to one word SHALL return the old data (read-first).
REQ-024 Write data beats presented before the AW handshake SHALL be back-pressured (wready=0 in W_IDLE).

Reset
REQ-025 On reset both FSMs SHALL go idle; awready=arready=1, wready=bvalid=rvalid=rlast=0, bresp=rresp=0, IDs 0, in-flight bursts abandoned without response.
REQ-026 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-027 A shared package SHALL hold the AXI burst encodings (FIXED/INCR/WRAP), resp codes (OKAY/SLVERR/DECERR) and the FSM state enums.
REQ-028 Storage SHALL be one sub-module, scratchpad_ram: 1R1W, DEPTH x 64, 8-bit byte-write enable, 1-cycle synchronous read, read-first.

Verification
REQ-029 INCR write len=3 size=3 at BASE+0x40, data 1..4, strb 8'hFF -> bresp OKAY; INCR read same -> rdata 1,2,3,4, rlast on beat 4 only, rid=awid.
REQ-030 Write 64'h1122334455667788 with strb 8'h0F onto 0 -> read returns 64'h0000000055667788.
REQ-031 WRAP read len=3 size=3 at BASE+0x18 -> word order 3,0,1,2; FIXED read len=2 -> same word 3 times.
REQ-032 AR at BASE+0x1000 len=1 -> two beats, rresp 2'b11, rdata 0; AW burst=2'b11 -> bresp 2'b10, memory unchanged.
REQ-033 rready held low 10 cycles -> rvalid, rdata, rlast stable; bready low -> bvalid held, awready=0.
REQ-034 reset asserted mid write burst (beat 2 of 4) -> next cycle awready=1, bvalid=0; earlier-written beats retained.
